// File: rtl/tb_pkg.sv
// Shared survivor-memory constants and traceback FSM encoding, used by both the
// survivor memory writer and the traceback reader.
package tb_pkg;

   localparam int DEF_NROWS     = 64;
   localparam int DEF_ADDR_BITS = 6;
   localparam int DEF_NBITS     = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } tb_state_t;

endpackage

// File: rtl/survivor_traceback.sv
// Survivor-memory traceback: walks TB_LEN rows backwards from last_addr, following
// the survivor path from best_state, and emits the oldest DEC_LEN decisions.
module survivor_traceback
   import tb_pkg::*;
#(
   parameter int NROWS     = DEF_NROWS,
   parameter int ADDR_BITS = DEF_ADDR_BITS,
   parameter int NBITS     = DEF_NBITS,
   parameter int TB_LEN    = 32,
   parameter int DEC_LEN   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_BITS-1:0] last_addr,
   input  logic [1:0]           best_state,
   output logic                 ram_cs,
   output logic                 ram_rws,
   output logic [ADDR_BITS-1:0] ram_cr,
   output logic [NBITS-1:0]     ram_i,
   input  logic [NBITS-1:0]     ram_o,
   output logic                 busy,
   output logic                 dec_valid,
   output logic                 dec_bit,
   output logic                 done
);

   localparam int KW = $clog2(TB_LEN + 1);
   localparam logic [KW-1:0]        K_LAST = KW'(TB_LEN - 1);
   localparam logic [KW-1:0]        K_DEC  = KW'(TB_LEN - DEC_LEN);
   localparam logic [ADDR_BITS-1:0] A_WRAP = ADDR_BITS'(NROWS - 1);

   tb_state_t              state_reg, state_next;
   logic [KW-1:0]          k_reg, k_next;
   logic [ADDR_BITS-1:0]   a_reg, a_next;
   logic [1:0]             s_reg, s_next;
   logic                   dec_bit_reg, dec_bit_next;
   logic                   dec_valid_reg, dec_valid_next;
   logic                   surv_bit;

   // Survivor decision for the state currently being traced.
   assign surv_bit = ram_o[s_reg];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         k_reg         <= '0;
         a_reg         <= '0;
         s_reg         <= '0;
         dec_bit_reg   <= 1'b0;
         dec_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         k_reg         <= k_next;
         a_reg         <= a_next;
         s_reg         <= s_next;
         dec_bit_reg   <= dec_bit_next;
         dec_valid_reg <= dec_valid_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      k_next         = k_reg;
      a_next         = a_reg;
      s_next         = s_reg;
      dec_bit_next   = dec_bit_reg;
      dec_valid_next = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_RUN;
               k_next     = '0;
               a_next     = last_addr;
               s_next     = best_state;
            end
         end
         ST_RUN: begin
            s_next = {s_reg[0], surv_bit};
            // Explicit wrap keeps the walk inside the memory when NROWS is not a power of two.
            a_next = (a_reg == '0) ? A_WRAP : a_reg - ADDR_BITS'(1);
            k_next = k_reg + KW'(1);
            if (k_reg >= K_DEC) begin
               dec_bit_next   = s_reg[1];
               dec_valid_next = 1'b1;
            end
            if (k_reg == K_LAST) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign ram_cs    = (state_reg == ST_RUN);
   assign ram_cr    = (state_reg == ST_RUN) ? a_reg : '0;
   assign ram_rws   = 1'b0;
   assign ram_i     = '0;
   assign busy      = (state_reg != ST_IDLE);
   assign done      = (state_reg == ST_DONE);
   assign dec_valid = dec_valid_reg;
   assign dec_bit   = dec_bit_reg;

endmodule

// File: tb/tb_survivor_traceback.sv
// Directed bench for survivor_traceback: uniform-fill survivor memories give
// hand-traceable paths; extra sequences cover restart, mid-run reset and short traceback.
module tb_survivor_traceback;
   import tb_pkg::*;

   localparam int AW = 6;
   localparam int TBL = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] last_addr = '0;
   logic [1:0]    best_state = '0;
   logic          ram_cs, ram_rws;
   logic [AW-1:0] ram_cr;
   logic [3:0]    ram_i, ram_o;
   logic          busy, dec_valid, dec_bit, done;
   logic [3:0]    mem [0:63];

   logic          start2 = 1'b0;
   logic [AW-1:0] last_addr2 = '0;
   logic          ram_cs2, ram_rws2;
   logic [AW-1:0] ram_cr2;
   logic [3:0]    ram_i2, ram_o2;
   logic          busy2, dec_valid2, dec_bit2, done2;

   always #5 clk = ~clk;

   assign ram_o  = (ram_cs && !ram_rws) ? mem[ram_cr] : 4'h0;
   assign ram_o2 = (ram_cs2 && !ram_rws2) ? 4'hF : 4'h0;

   survivor_traceback dut (
      .clk(clk), .rst(rst), .start(start), .last_addr(last_addr), .best_state(best_state),
      .ram_cs(ram_cs), .ram_rws(ram_rws), .ram_cr(ram_cr), .ram_i(ram_i), .ram_o(ram_o),
      .busy(busy), .dec_valid(dec_valid), .dec_bit(dec_bit), .done(done)
   );

   survivor_traceback #(.NROWS(64), .ADDR_BITS(6), .NBITS(4), .TB_LEN(4), .DEC_LEN(4)) dut4 (
      .clk(clk), .rst(rst), .start(start2), .last_addr(last_addr2), .best_state(2'b00),
      .ram_cs(ram_cs2), .ram_rws(ram_rws2), .ram_cr(ram_cr2), .ram_i(ram_i2), .ram_o(ram_o2),
      .busy(busy2), .dec_valid(dec_valid2), .dec_bit(dec_bit2), .done(done2)
   );

   typedef struct {
      logic [3:0] fill;
      logic [5:0] la;
      logic [1:0] bs;
      logic [7:0] exp_bits;
   } vec_t;

   typedef struct {
      logic [7:0] bits;
      int         ndec;
      int         done_c;
      int         ndone;
      int         addr_err;
      int         cs_err;
      logic       dv_done;
      logic       busy_post;
      logic       busy_rst;
      logic       bit_rst;
   } res_t;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fill_mem(input logic [3:0] v);
      for (int i = 0; i < 64; i++) mem[i] = v;
   endtask

   // Starts a traceback at the current negedge and monitors it cycle by cycle;
   // c counts cycles after the start-sampling edge.
   task automatic run_trace(input logic [5:0] la, input logic [1:0] bs,
                            input int restart_c, input int rst_c, output res_t r);
      logic          exp_cs;
      logic [AW-1:0] ea;
      r.bits = '0; r.ndec = 0; r.done_c = -1; r.ndone = 0; r.addr_err = 0;
      r.cs_err = 0; r.dv_done = 1'b0; r.busy_post = 1'b1; r.busy_rst = 1'b1; r.bit_rst = 1'b1;
      last_addr = la; best_state = bs; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 45; c++) begin
         exp_cs = (c <= ((rst_c > 0) ? rst_c : TBL));
         if (ram_cs !== exp_cs) r.cs_err++;
         if (ram_rws !== 1'b0 || ram_i !== 4'h0) r.cs_err++;
         ea = la - AW'(c - 1);
         if (ram_cs && ram_cr !== ea) r.addr_err++;
         if (!ram_cs && ram_cr !== '0) r.addr_err++;
         if (dec_valid) begin
            r.ndec++;
            r.bits = {r.bits[6:0], dec_bit};
         end
         if (done) begin
            r.ndone++;
            if (r.done_c < 0) r.done_c = c;
            r.dv_done = dec_valid;
         end
         if (rst_c > 0 && c == rst_c + 1) begin
            r.busy_rst = busy;
            r.bit_rst  = dec_bit;
         end
         start = (c == restart_c);
         rst   = (rst_c > 0 && c == rst_c);
         @(negedge clk);
         if (rst_c == 0 && r.done_c == c) break;
      end
      start = 1'b0;
      rst = 1'b0;
      r.busy_post = busy;
   endtask

   vec_t vecs [8];
   res_t r;

   initial begin
      // uniform fills; paths traced by hand from best_state
      vecs[0] = '{4'b0000, 6'd5,  2'd0, 8'b0000_0000};
      vecs[1] = '{4'b1111, 6'd20, 2'd0, 8'b1111_1111};
      vecs[2] = '{4'b0101, 6'd63, 2'd0, 8'b1010_1010};
      vecs[3] = '{4'b1010, 6'd0,  2'd0, 8'b0000_0000};
      vecs[4] = '{4'b1010, 6'd40, 2'd3, 8'b1111_1111};
      vecs[5] = '{4'b1010, 6'd17, 2'd2, 8'b0000_0000};
      vecs[6] = '{4'b0011, 6'd33, 2'd0, 8'b0011_0011};
      vecs[7] = '{4'b0011, 6'd9,  2'd2, 8'b1001_1001};
      fill_mem(4'h0);

      // reset, with start held high to confirm reset wins
      rst = 1'b1; start = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_dec_valid", dec_valid, 0);
      check("rst_dec_bit", dec_bit, 0);
      check("rst_ram_cs", ram_cs, 0);
      check("rst_ram_cr", ram_cr, 0);
      check("rst_ram_rws", ram_rws, 0);
      check("rst_ram_i", ram_i, 0);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check("idle_after_rst", busy, 0);

      // second start during RUN must be ignored
      fill_mem(4'h0);
      run_trace(6'd5, 2'd0, 10, 0, r);
      $display("restart: done_c=%0d ndone=%0d ndec=%0d", r.done_c, r.ndone, r.ndec);
      check("restart_ndone", r.ndone, 1);
      check("restart_ndec", r.ndec, 8);
      check("restart_done_c", r.done_c, 33);
      check("restart_no_queue", r.busy_post, 0);

      for (int v = 0; v < 8; v++) begin
         fill_mem(vecs[v].fill);
         run_trace(vecs[v].la, vecs[v].bs, 0, 0, r);
         $display("vec %0d fill=%b la=%0d bs=%0d bits=%b done_c=%0d ndec=%0d",
                  v, vecs[v].fill, vecs[v].la, vecs[v].bs, r.bits, r.done_c, r.ndec);
         check($sformatf("v%0d_bits", v), r.bits, vecs[v].exp_bits);
         check($sformatf("v%0d_ndec", v), r.ndec, 8);
         check($sformatf("v%0d_done_c", v), r.done_c, 33);
         check($sformatf("v%0d_ndone", v), r.ndone, 1);
         check($sformatf("v%0d_addr_err", v), r.addr_err, 0);
         check($sformatf("v%0d_cs_err", v), r.cs_err, 0);
         check($sformatf("v%0d_dv_at_done", v), r.dv_done, 1);
      end

      // mid-run reset at RUN cycle 12; dec_bit was left at 1 by the previous vector
      fill_mem(4'hF);
      run_trace(6'd30, 2'd0, 0, 12, r);
      $display("midrst: busy=%0d dec_bit=%0d ndone=%0d ndec=%0d cs_err=%0d",
               r.busy_rst, r.bit_rst, r.ndone, r.ndec, r.cs_err);
      check("midrst_busy", r.busy_rst, 0);
      check("midrst_dec_bit", r.bit_rst, 0);
      check("midrst_ndone", r.ndone, 0);
      check("midrst_ndec", r.ndec, 0);
      check("midrst_cs_err", r.cs_err, 0);
      check("midrst_addr_err", r.addr_err, 0);

      // short traceback, all rows 1111: states 00,01,11,11 -> bits 0,0,1,1
      begin
         logic [3:0] bits4;
         int nd, dc, fdv, aerr;
         logic dvd;
         bits4 = '0; nd = 0; dc = -1; fdv = -1; aerr = 0; dvd = 1'b0;
         last_addr2 = 6'd2; start2 = 1'b1;
         @(negedge clk);
         start2 = 1'b0;
         for (int c = 1; c <= 10; c++) begin
            if (ram_cs2 && ram_cr2 !== AW'(6'd2 - AW'(c - 1))) aerr++;
            if (dec_valid2) begin
               nd++;
               bits4 = {bits4[2:0], dec_bit2};
               if (fdv < 0) fdv = c;
            end
            if (done2) begin
               dc = c;
               dvd = dec_valid2;
            end
            @(negedge clk);
            if (dc == c) break;
         end
         $display("short: bits=%b ndec=%0d done_c=%0d first_dv=%0d", bits4, nd, dc, fdv);
         check("short_bits", bits4, 4'b0011);
         check("short_ndec", nd, 4);
         check("short_done_c", dc, 5);
         check("short_first_dv", fdv, 2);
         check("short_dv_at_done", dvd, 1);
         check("short_addr_err", aerr, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/survivor_traceback.md
SURVIVOR_TRACEBACK -- requirements
Module: survivor_traceback

Interface
REQ-001 SHALL have parameter NROWS, default 64, survivor memory depth in rows.
REQ-002 SHALL have parameter ADDR_BITS, default 6, survivor memory address width.
REQ-003 SHALL have parameter NBITS, default 4, survivor bits per row (one per trellis state).
REQ-004 SHALL have parameter TB_LEN, default 32, rows walked per traceback.
REQ-005 SHALL have parameter DEC_LEN, default 8, decoded bits emitted per traceback; legal range 1 <= DEC_LEN <= TB_LEN <= NROWS.
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-007 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have port start, input, 1, request one traceback; sampled only in IDLE.
REQ-009 SHALL have port last_addr, input, ADDR_BITS, newest written survivor row; captured with start.
REQ-010 SHALL have port best_state, input, 2, initial trellis state; captured with start.
REQ-011 SHALL have port ram_cs, output, 1, survivor memory chip select.
REQ-012 SHALL have port ram_rws, output, 1, survivor memory read/write select (1 = write).
REQ-013 SHALL have port ram_cr, output, ADDR_BITS, survivor memory row address.
REQ-014 SHALL have port ram_i, output, NBITS, survivor memory write data.
REQ-015 SHALL have port ram_o, input, NBITS, survivor memory read data; valid combinationally while ram_cs=1 and ram_rws=0.
REQ-016 SHALL have port busy, output, 1, traceback in progress.
REQ-017 SHALL have port dec_valid, output, 1, dec_bit qualifier.
REQ-018 SHALL have port dec_bit, output, 1, decoded bit, oldest-last order.
REQ-019 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, DONE: IDLE->RUN on start=1; RUN->DONE after TB_LEN RUN cycles; DONE->IDLE unconditionally after one cycle.
REQ-021 SHALL, on leaving IDLE, load row counter k=0, address register a=last_addr, trellis state s=best_state.
REQ-022 SHALL, in RUN, drive ram_cs=1, ram_cr=a; SHALL drive ram_cs=0 and ram_cr=0 in IDLE and DONE.
REQ-023 SHALL drive ram_rws=0 and ram_i=0 in every state (the block is a read-only master).
REQ-024 SHALL, each RUN cycle, sample b=ram_o[s] at the clock edge; then s<=(s[0],b), a<=a-1 mod 2^ADDR_BITS (row 0 wraps to NROWS-1), k<=k+1.
REQ-025 SHALL, for RUN cycles with k >= TB_LEN-DEC_LEN, register dec_bit<=s[1] (pre-update s) and dec_valid<=1 for the following cycle; otherwise dec_valid<=0 and dec_bit holds.
REQ-026 SHALL assert busy=1 in RUN and DONE, 0 in IDLE; start while busy=1 SHALL be ignored without queuing.
REQ-027 SHALL assert done=1 exactly in the DONE cycle; the last dec_valid coincides with done.
REQ-028 Latency: start sampled at edge E0 -> first read address presented in cycle after E0; done asserted TB_LEN+1 cycles after E0.
REQ-029 SHALL accept start in the cycle after done (back-to-back tracebacks, one IDLE cycle between).

Reset
REQ-030 SHALL, when rst=1 at a clock edge, go to IDLE regardless of state, including mid-RUN, discarding the traceback.
REQ-031 Reset values: busy=0, done=0, dec_valid=0, dec_bit=0, ram_cs=0, ram_rws=0, ram_cr=0, ram_i=0, k=0, a=0, s=0.
REQ-032 SHALL give rst priority over start in the same cycle.

Structure
REQ-033 SHALL place FSM state encoding and default NROWS/ADDR_BITS/NBITS constants in a shared package tb_pkg, also used by the survivor memory writer.
REQ-034 SHALL be a single module; no sub-module required, address decrement inline.

Verification
REQ-035 All-zero memory, last_addr=5, best_state=0, start -> ram_cr 5,4,...,0,63,...,38 (32 reads), 8 dec_valid with dec_bit=0, done 33 cycles after start edge.
REQ-036 All rows 4'b1111, best_state=0, DEC_LEN=TB_LEN=4 -> states 00,01,11,11; dec_bit sequence 0,0,1,1.
REQ-037 start pulsed again at RUN cycle 10 -> ignored; exactly one done, exactly 8 dec_valid.
REQ-038 rst asserted at RUN cycle 12 -> next cycle busy=0, ram_cs=0, no done, no further dec_valid.
REQ-039 start asserted the cycle after done with last_addr=63 -> second traceback reads 63..32, completes normally.
REQ-040 All cycles: ram_rws=0, ram_i=0; ram_cs=1 only while in RUN.
